// File: rtl/ifu_fetch.sv
// ifu_fetch: instruction-fetch front end with a single outstanding memory request,
// a one-entry instruction buffer toward decode, and branch-redirect flushing.
module ifu_fetch #(
   parameter logic [63:0] RESET_PC = 64'h0000_0000_8000_0000,
   parameter int          INST_W   = 32
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              bmu_vld,
   input  logic              ifetch_taken,
   input  logic [63:0]       ifetch_taken_pc,
   output logic              req_vld,
   input  logic              req_rdy,
   output logic [63:0]       req_addr,
   input  logic              rsp_vld,
   input  logic [INST_W-1:0] rsp_data,
   output logic              idu_vld,
   input  logic              idu_rdy,
   output logic [INST_W-1:0] idu_inst,
   output logic [63:0]       idu_pc,
   output logic              flush
);
   typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_HOLD} state_t;

   state_t      state;
   logic [63:0] pc;
   logic        kill;
   logic        redirect;

   assign redirect = bmu_vld & ifetch_taken;
   assign flush    = redirect;
   assign req_vld  = state == S_REQ;
   assign req_addr = req_vld ? pc : '0;
   // The mask keeps a wrong-path instruction from ever completing a handshake.
   assign idu_vld  = (state == S_HOLD) & ~redirect;

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= S_IDLE;
         pc       <= RESET_PC;
         kill     <= 1'b0;
         idu_inst <= '0;
         idu_pc   <= '0;
      end else begin
         case (state)
            S_IDLE: state <= S_REQ;
            S_REQ: begin
               if (redirect) pc <= ifetch_taken_pc;
               if (req_rdy) begin
                  state <= S_WAIT;
                  kill  <= redirect;
               end
            end
            S_WAIT: begin
               if (rsp_vld) begin
                  if (kill | redirect) begin
                     kill  <= 1'b0;
                     state <= S_REQ;
                     if (redirect) pc <= ifetch_taken_pc;
                  end else begin
                     idu_inst <= rsp_data;
                     idu_pc   <= pc;
                     state    <= S_HOLD;
                  end
               end else if (redirect) begin
                  pc   <= ifetch_taken_pc;
                  kill <= 1'b1;
               end
            end
            S_HOLD: begin
               if (redirect) begin
                  pc    <= ifetch_taken_pc;
                  state <= S_REQ;
               end else if (idu_rdy) begin
                  pc    <= pc + 64'd4;
                  state <= S_REQ;
               end
            end
            default: state <= S_IDLE;
         endcase
      end
   end
endmodule
